// File: rtl/gat_pkg.sv
// Shared definitions for the GAT feature readback path: readback FSM states,
// beat packing factor, BRAM read-latency bounds and the tkeep helper.
package gat_pkg;

    typedef enum logic [1:0] {
        FEAT_RD_IDLE  = 2'd0,
        FEAT_RD_READ  = 2'd1,
        FEAT_RD_DRAIN = 2'd2,
        FEAT_RD_DONE  = 2'd3
    } feat_rd_state_e;

    localparam int AXIS_DATA_W       = 32;
    localparam int AXIS_KEEP_W       = AXIS_DATA_W / 8;
    localparam int FEAT_DATA_W_DEF   = 8;

    // Supported BRAM read latencies (address cycle to data valid).
    localparam int BRAM_RD_LAT_MIN   = 1;
    localparam int BRAM_RD_LAT_MAX   = 3;

    // Features per 32-bit beat for a given feature width.
    function automatic int pack_of(input int dw);
        return AXIS_DATA_W / dw;
    endfunction

    // Default packing factor (8-bit features).
    localparam int PACK = AXIS_DATA_W / FEAT_DATA_W_DEF;

    // Byte enables for a beat whose lowest 'slots' feature slots are valid.
    function automatic logic [3:0] keep_from_slots(input int unsigned slots,
                                                   input int unsigned bytes_per_slot);
        logic [3:0] keep;
        keep = 4'b0000;
        for (int unsigned b = 0; b < 32'd4; b++) begin
            if (b < slots * bytes_per_slot) begin
                keep[b] = 1'b1;
            end else begin
                keep[b] = 1'b0;
            end
        end
        return keep;
    endfunction

endpackage

// File: rtl/gat_stream_fifo.sv
// Synchronous FIFO with occupancy count; simultaneous push and pop are
// allowed, including push while full when a pop happens in the same cycle.
// DEPTH must be a power of two so the pointers wrap naturally.
module gat_stream_fifo
    import gat_pkg::*;
#(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify push/pop against the current occupancy.
    always_comb begin
        do_pop_s  = pop && (count_r != CNT_W'(0));
        do_push_s = push && ((count_r != CNT_W'(DEPTH)) || do_pop_s);
    end

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r        <= wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign pop_data = mem_r[rd_ptr_r];
    assign full     = (count_r == CNT_W'(DEPTH));
    assign empty    = (count_r == CNT_W'(0));
    assign count    = count_r;

endmodule

// File: rtl/gat_feat_stream_reader.sv
// Drains the GAT new-feature BRAM after a layer completes and packs the
// features into 32-bit AXI-Stream beats for the output DMA.
// Optional build macro FEAT_STREAM_RELU_EN: clamp negative (signed) features
// to zero in the packer stage.
module gat_feat_stream_reader
    import gat_pkg::*;
#(
    parameter int DATA_WIDTH         = 8,
    parameter int NUM_SUBGRAPHS      = 2708,
    parameter int NUM_FEATURE_OUT    = 16,
    parameter int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
    parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
    parameter int BRAM_RD_LATENCY    = 2,
    parameter int FIFO_DEPTH         = 4
)(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          gat_ready,
    output logic                          busy,
    output logic                          done,
    output logic                          feat_bram_enb,
    output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
    input  logic [31:0]                   feat_bram_dout,
    output logic [31:0]                   m_axis_tdata,
    output logic [3:0]                    m_axis_tkeep,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [31:0]                   beat_cnt
);

    localparam int SLOTS      = pack_of(DATA_WIDTH);
    localparam int SLOT_BYTES = DATA_WIDTH / 8;
    localparam int LAT        = (BRAM_RD_LATENCY < BRAM_RD_LAT_MIN) ? BRAM_RD_LAT_MIN :
                                (BRAM_RD_LATENCY > BRAM_RD_LAT_MAX) ? BRAM_RD_LAT_MAX :
                                BRAM_RD_LATENCY;
    localparam int PCNT_W     = $clog2(SLOTS + 1);
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int FIFO_W     = AXIS_DATA_W + AXIS_KEEP_W + 1;
    localparam int CREDIT_MAX = SLOTS * FIFO_DEPTH;
    localparam logic [NEW_FEATURE_ADDR_W-1:0] LAST_IDX =
        NEW_FEATURE_ADDR_W'(NEW_FEATURE_DEPTH - 1);

    feat_rd_state_e                  state_r, state_s;
    logic [NEW_FEATURE_ADDR_W-1:0]   rd_idx_r;
    logic                            issue_r, issue_last_r;
    logic [NEW_FEATURE_ADDR_W+1:0]   addr_r;
    logic [LAT-1:0]                  tag_r, tag_last_r;
    logic [PCNT_W-1:0]               pack_cnt_r;
    logic [31:0]                     pack_data_r;
    logic                            busy_r, done_r;
    logic [31:0]                     beat_cnt_r;

    logic                            issue_s, start_run_s, credit_ok_s;
    logic [31:0]                     in_flight_s;
    logic                            ret_s, ret_last_s;
    logic [DATA_WIDTH-1:0]           feat_s;
    logic [31:0]                     merged_s;
    logic                            push_s, pop_s;
    logic [FIFO_W-1:0]               push_data_s, head_s;
    logic                            empty_s, full_s;
    logic [CNT_W-1:0]                fifo_count_s;

    generate
        if (DATA_WIDTH < 32) begin : g_dout_hi
            logic unused_dout_hi;
            assign unused_dout_hi = ^feat_bram_dout[31:DATA_WIDTH];
        end
    endgenerate

    // Credit check: everything issued, being packed or queued must fit the FIFO.
    always_comb begin
        in_flight_s = 32'(issue_r);
        for (int i = 0; i < LAT; i++) begin
            in_flight_s = in_flight_s + 32'(tag_r[i]);
        end
        credit_ok_s = (in_flight_s + 32'(pack_cnt_r) + 32'(SLOTS) * 32'(fifo_count_s))
                      < 32'(CREDIT_MAX);
    end

    // Readback FSM next-state and issue decision.
    always_comb begin
        state_s     = state_r;
        issue_s     = 1'b0;
        start_run_s = 1'b0;
        case (state_r)
            FEAT_RD_IDLE: begin
                if (start && gat_ready) begin
                    state_s     = FEAT_RD_READ;
                    start_run_s = 1'b1;
                end else begin
                    state_s     = FEAT_RD_IDLE;
                end
            end
            FEAT_RD_READ: begin
                if (credit_ok_s) begin
                    issue_s = 1'b1;
                    if (rd_idx_r == LAST_IDX) begin
                        state_s = FEAT_RD_DRAIN;
                    end else begin
                        state_s = FEAT_RD_READ;
                    end
                end else begin
                    state_s = FEAT_RD_READ;
                end
            end
            FEAT_RD_DRAIN: begin
                if (!issue_r && (tag_r == '0) && (pack_cnt_r == '0) && empty_s) begin
                    state_s = FEAT_RD_DONE;
                end else begin
                    state_s = FEAT_RD_DRAIN;
                end
            end
            FEAT_RD_DONE: begin
                state_s = FEAT_RD_IDLE;
            end
            default: begin
                state_s = FEAT_RD_IDLE;
            end
        endcase
    end

    // State register plus registered busy/done status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= FEAT_RD_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == FEAT_RD_READ) || (state_s == FEAT_RD_DRAIN);
            done_r  <= (state_s == FEAT_RD_DONE);
        end
    end

    // Registered BRAM read port and the valid/last tags riding with each read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_idx_r     <= '0;
            issue_r      <= 1'b0;
            issue_last_r <= 1'b0;
            addr_r       <= '0;
            tag_r        <= '0;
            tag_last_r   <= '0;
        end else begin
            issue_r      <= issue_s;
            issue_last_r <= issue_s && (rd_idx_r == LAST_IDX);
            tag_r        <= (tag_r << 1) | LAT'(issue_r);
            tag_last_r   <= (tag_last_r << 1) | LAT'(issue_last_r);
            if (issue_s) begin
                addr_r <= {rd_idx_r, 2'b00};
            end else begin
                addr_r <= addr_r;
            end
            if (start_run_s) begin
                rd_idx_r <= '0;
            end else if (issue_s) begin
                rd_idx_r <= rd_idx_r + NEW_FEATURE_ADDR_W'(1);
            end else begin
                rd_idx_r <= rd_idx_r;
            end
        end
    end

    // Returned feature (optionally clamped) merged into the beat under construction.
    always_comb begin
        ret_s      = tag_r[LAT-1];
        ret_last_s = tag_last_r[LAT-1];
        feat_s     = feat_bram_dout[DATA_WIDTH-1:0];
`ifdef FEAT_STREAM_RELU_EN
        if (feat_s[DATA_WIDTH-1]) begin
            feat_s = '0;
        end else begin
            feat_s = feat_bram_dout[DATA_WIDTH-1:0];
        end
`endif
        merged_s    = pack_data_r | (32'(feat_s) << (DATA_WIDTH * 32'(pack_cnt_r)));
        push_s      = ret_s && ((pack_cnt_r == PCNT_W'(SLOTS - 1)) || ret_last_s);
        push_data_s = {merged_s,
                       keep_from_slots(32'(pack_cnt_r) + 32'd1, 32'(SLOT_BYTES)),
                       ret_last_s};
        pop_s       = !empty_s && m_axis_tready;
    end

    // Packer slot counter and partial beat accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_cnt_r  <= '0;
            pack_data_r <= '0;
        end else if (start_run_s || push_s) begin
            pack_cnt_r  <= '0;
            pack_data_r <= '0;
        end else if (ret_s) begin
            pack_cnt_r  <= pack_cnt_r + PCNT_W'(1);
            pack_data_r <= merged_s;
        end else begin
            pack_cnt_r  <= pack_cnt_r;
            pack_data_r <= pack_data_r;
        end
    end

    // Count of beats accepted downstream in the current run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_r <= 32'd0;
        end else if (start_run_s) begin
            beat_cnt_r <= 32'd0;
        end else if (pop_s) begin
            beat_cnt_r <= beat_cnt_r + 32'd1;
        end else begin
            beat_cnt_r <= beat_cnt_r;
        end
    end

    gat_stream_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .pop_data  (head_s),
        .full      (full_s),
        .empty     (empty_s),
        .count     (fifo_count_s)
    );

    logic unused_full;
    assign unused_full = full_s;

    assign busy            = busy_r;
    assign done            = done_r;
    assign feat_bram_enb   = issue_r;
    assign feat_bram_addrb = addr_r;
    assign m_axis_tvalid   = !empty_s;
    assign m_axis_tdata    = head_s[FIFO_W-1 -: 32];
    assign m_axis_tkeep    = head_s[4:1];
    assign m_axis_tlast    = head_s[0];
    assign beat_cnt        = beat_cnt_r;

endmodule

// File: tb/tb_gat_feat_stream_reader.sv
// Bench for gat_feat_stream_reader: five DUT configurations run side by side,
// each with its own BRAM image and an index-arithmetic model of the stream.
`timescale 1ns/1ps
module tb_gat_feat_stream_reader;

    localparam int NCFG = 5;

    function automatic int ns_of(input int g);
        case (g)
            0: return 2708;
            1: return 3;
            2: return 3;
            3: return 200;
            default: return 1;
        endcase
    endfunction

    function automatic int nf_of(input int g);
        case (g)
            0: return 16;
            1: return 4;
            2: return 2;
            default: return 4;
        endcase
    endfunction

    function automatic int depth_of(input int g);
        return ns_of(g) * nf_of(g);
    endfunction

    function automatic int nbeats_of(input int g);
        return (depth_of(g) + 3) / 4;
    endfunction

    // BRAM image per configuration.
    function automatic logic [7:0] feat_of(input int g, input int idx);
        case (g)
            0: return 8'((idx * 37 + 11) ^ (idx >> 8));
            1: return 8'(idx + 1);
            2: return 8'(8'h11 + idx);
            3: return 8'(idx * 5 + 1);
            default: begin
                case (idx)
                    0: return 8'h80;
                    1: return 8'hFF;
                    2: return 8'h7F;
                    default: return 8'h00;
                endcase
            end
        endcase
    endfunction

    function automatic logic [7:0] relu(input logic [7:0] v);
`ifdef FEAT_STREAM_RELU_EN
        return v[7] ? 8'h00 : v;
`else
        return v;
`endif
    endfunction

    // Expected beat j: features 4j..4j+3 little-end first, missing ones zero.
    function automatic logic [31:0] exp_data(input int g, input int j);
        logic [31:0] d;
        d = 32'd0;
        for (int k = 0; k < 4; k++) begin
            if (4 * j + k < depth_of(g)) d[8*k +: 8] = relu(feat_of(g, 4 * j + k));
        end
        return d;
    endfunction

    function automatic logic [3:0] exp_keep(input int g, input int j);
        logic [3:0] kp;
        kp = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            if (4 * j + k < depth_of(g)) kp[k] = 1'b1;
        end
        return kp;
    endfunction

    logic        clk;
    logic        rst_n_a   [NCFG];
    logic        start_a   [NCFG];
    logic        gat_rdy_a [NCFG];
    logic        tready_a  [NCFG];
    logic        busy_a    [NCFG];
    logic        done_a    [NCFG];
    logic        tvalid_a  [NCFG];
    logic        tlast_a   [NCFG];
    logic [31:0] tdata_a   [NCFG];
    logic [3:0]  tkeep_a   [NCFG];
    logic [31:0] bcnt_a    [NCFG];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int NS  = ns_of(g);
        localparam int NF  = nf_of(g);
        localparam int DEP = NS * NF;
        localparam int AW  = $clog2(DEP);

        logic          enb;
        logic [AW+1:0] addrb;
        logic [31:0]   dout = 32'd0;
        int            a_q  = -1;

        // Two-cycle BRAM: address registered when enabled, data one cycle later.
        always @(posedge clk) begin
            a_q <= enb ? int'(addrb >> 2) : -1;
            if (a_q >= 0 && a_q < DEP) dout <= {24'hA5A5A5, feat_of(g, a_q)};
            else dout <= 32'hDEADBEEF;
        end

        gat_feat_stream_reader #(
            .DATA_WIDTH      (8),
            .NUM_SUBGRAPHS   (NS),
            .NUM_FEATURE_OUT (NF),
            .BRAM_RD_LATENCY (2),
            .FIFO_DEPTH      (4)
        ) u_dut (
            .clk             (clk),
            .rst_n           (rst_n_a[g]),
            .start           (start_a[g]),
            .gat_ready       (gat_rdy_a[g]),
            .busy            (busy_a[g]),
            .done            (done_a[g]),
            .feat_bram_enb   (enb),
            .feat_bram_addrb (addrb),
            .feat_bram_dout  (dout),
            .m_axis_tdata    (tdata_a[g]),
            .m_axis_tkeep    (tkeep_a[g]),
            .m_axis_tvalid   (tvalid_a[g]),
            .m_axis_tready   (tready_a[g]),
            .m_axis_tlast    (tlast_a[g]),
            .beat_cnt        (bcnt_a[g])
        );

        int          j        = 0;
        int          done_cnt = 0;
        logic        stall_q  = 1'b0;
        logic        done_q   = 1'b0;
        logic [36:0] held_q   = '0;
        logic [31:0] log_d [8];
        logic [3:0]  log_k [8];
        logic        log_l [8];

        // Per-cycle compare of the stream against the model.
        always @(negedge clk) begin
            if (!rst_n_a[g]) begin
                j       <= 0;
                stall_q <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                if (stall_q) begin
                    check("hold_valid", 64'(tvalid_a[g]), 64'd1);
                    check("hold_beat", 64'({tdata_a[g], tkeep_a[g], tlast_a[g]}), 64'(held_q));
                end
                if (tvalid_a[g] && tready_a[g]) begin
                    check("beat_data", 64'(tdata_a[g]), 64'(exp_data(g, j)));
                    check("beat_keep", 64'(tkeep_a[g]), 64'(exp_keep(g, j)));
                    check("beat_last", 64'(tlast_a[g]), 64'(j == nbeats_of(g) - 1));
                    if (j < 8) begin
                        log_d[j] <= tdata_a[g];
                        log_k[j] <= tkeep_a[g];
                        log_l[j] <= tlast_a[g];
                    end
                    j <= j + 1;
                end
                stall_q <= tvalid_a[g] && !tready_a[g];
                held_q  <= {tdata_a[g], tkeep_a[g], tlast_a[g]};
                done_q  <= done_a[g];
                if (done_a[g]) begin
                    check("done_single", 64'(done_q), 64'd0);
                    check("stream_len", 64'(j), 64'(nbeats_of(g)));
                    j        <= 0;
                    done_cnt <= done_cnt + 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int g);
        start_a[g] = 1'b1;
        tick();
        start_a[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input int budget, input bit rnd, input string name);
        int c;
        c = 0;
        while (!done_a[g] && c < budget) begin
            if (rnd) tready_a[g] = ($urandom_range(0, 9) < 3);
            tick();
            c++;
        end
        check(name, 64'(done_a[g]), 64'd1);
        tready_a[g] = 1'b1;
        tick();
    endtask

    logic [31:0] relu_exp;

    initial begin
        int c;
        for (int g = 0; g < NCFG; g++) begin
            rst_n_a[g]   = 1'b0;
            start_a[g]   = 1'b0;
            gat_rdy_a[g] = 1'b1;
            tready_a[g]  = 1'b1;
        end
        repeat (3) tick();

        check("rst_busy",   64'(busy_a[0]),        64'd0);
        check("rst_done",   64'(done_a[0]),        64'd0);
        check("rst_tvalid", 64'(tvalid_a[0]),      64'd0);
        check("rst_tlast",  64'(tlast_a[0]),       64'd0);
        check("rst_tdata",  64'(tdata_a[0]),       64'd0);
        check("rst_tkeep",  64'(tkeep_a[0]),       64'd0);
        check("rst_bcnt",   64'(bcnt_a[0]),        64'd0);
        check("rst_enb",    64'(g_cfg[0].enb),     64'd0);
        check("rst_addrb",  64'(g_cfg[0].addrb),   64'd0);

        for (int g = 0; g < NCFG; g++) rst_n_a[g] = 1'b1;
        tick();

        // Continuous drain, 12 features.
        pulse_start(1);
        wait_done(1, 200, 1'b0, "c1_done_timeout");
        check("c1_bcnt",  64'(bcnt_a[1]),            64'd3);
        check("c1_dones", 64'(g_cfg[1].done_cnt),    64'd1);
        check("c1_b0",    64'(g_cfg[1].log_d[0]),    64'h04030201);
        check("c1_b1",    64'(g_cfg[1].log_d[1]),    64'h08070605);
        check("c1_b2",    64'(g_cfg[1].log_d[2]),    64'h0C0B0A09);
        check("c1_k2",    64'(g_cfg[1].log_k[2]),    64'hF);
        check("c1_l0",    64'(g_cfg[1].log_l[0]),    64'd0);
        check("c1_l2",    64'(g_cfg[1].log_l[2]),    64'd1);

        // Partial final beat, 6 features.
        pulse_start(2);
        wait_done(2, 200, 1'b0, "c2_done_timeout");
        check("c2_bcnt", 64'(bcnt_a[2]),           64'd2);
        check("c2_b0",   64'(g_cfg[2].log_d[0]),   64'h14131211);
        check("c2_b1",   64'(g_cfg[2].log_d[1]),   64'h00001615);
        check("c2_k1",   64'(g_cfg[2].log_k[1]),   64'h3);
        check("c2_l1",   64'(g_cfg[2].log_l[1]),   64'd1);

        // Signed clamp behaviour on 0x80, 0xFF, 0x7F, 0x00.
`ifdef FEAT_STREAM_RELU_EN
        relu_exp = 32'h007F0000;
`else
        relu_exp = 32'h007FFF80;
`endif
        pulse_start(4);
        wait_done(4, 200, 1'b0, "c4_done_timeout");
        check("relu_beat", 64'(g_cfg[4].log_d[0]), 64'(relu_exp));
        check("relu_keep", 64'(g_cfg[4].log_k[0]), 64'hF);
        check("relu_last", 64'(g_cfg[4].log_l[0]), 64'd1);

        // Start gating: ignored without gat_ready, ignored while busy.
        gat_rdy_a[1] = 1'b0;
        pulse_start(1);
        repeat (3) tick();
        check("gate_busy", 64'(busy_a[1]), 64'd0);
        check("gate_bcnt", 64'(bcnt_a[1]), 64'd3);
        gat_rdy_a[1] = 1'b1;
        pulse_start(1);
        check("gate_run_busy", 64'(busy_a[1]), 64'd1);
        gat_rdy_a[1] = 1'b0;
        tick();
        pulse_start(1);
        wait_done(1, 200, 1'b0, "gate_done_timeout");
        repeat (10) tick();
        check("gate_dones", 64'(g_cfg[1].done_cnt), 64'd2);
        check("gate_bcnt2", 64'(bcnt_a[1]),         64'd3);
        check("gate_idle",  64'(busy_a[1]),         64'd0);
        gat_rdy_a[1] = 1'b1;

        // Full-size run under 30% tready.
        pulse_start(0);
        wait_done(0, 60000, 1'b1, "bp_done_timeout");
        check("bp_bcnt",  64'(bcnt_a[0]),         64'd10832);
        check("bp_dones", 64'(g_cfg[0].done_cnt), 64'd1);

        // Reset in the middle of a run, then a clean restart.
        pulse_start(3);
        c = 0;
        while (bcnt_a[3] != 32'd100 && c < 2000) begin
            tick();
            c++;
        end
        check("mid_reach_100", 64'(bcnt_a[3]), 64'd100);
        rst_n_a[3] = 1'b0;
        #1;
        check("mid_busy",   64'(busy_a[3]),      64'd0);
        check("mid_done",   64'(done_a[3]),      64'd0);
        check("mid_tvalid", 64'(tvalid_a[3]),    64'd0);
        check("mid_tlast",  64'(tlast_a[3]),     64'd0);
        check("mid_tdata",  64'(tdata_a[3]),     64'd0);
        check("mid_tkeep",  64'(tkeep_a[3]),     64'd0);
        check("mid_bcnt",   64'(bcnt_a[3]),      64'd0);
        check("mid_enb",    64'(g_cfg[3].enb),   64'd0);
        check("mid_addrb",  64'(g_cfg[3].addrb), 64'd0);
        tick();
        rst_n_a[3] = 1'b1;
        tick();
        pulse_start(3);
        wait_done(3, 3000, 1'b0, "mid_done_timeout");
        check("mid_bcnt2", 64'(bcnt_a[3]),         64'd200);
        check("mid_dones", 64'(g_cfg[3].done_cnt), 64'd1);
        check("mid_b0",    64'(g_cfg[3].log_d[0]), 64'h100B0601);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
